// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer: default widths, FSM encoding
// and the tap-count clamp applied when a sample is accepted.
package fir_pkg;

    localparam int FIR_DATA_W   = 8;
    localparam int FIR_COEF_W   = 8;
    localparam int FIR_MAX_TAPS = 16;

    typedef enum logic [0:0] {
        SEQ_IDLE   = 1'b0,
        SEQ_STREAM = 1'b1
    } seq_state_e;

    // Zero taps would never raise m_last, so it is promoted to a single tap.
    function automatic int unsigned clamp_taps(input logic [7:0] n, input int unsigned max_taps);
        if (n == 8'd0) begin
            return 32'd1;
        end
        if ({24'd0, n} > max_taps) begin
            return max_taps;
        end
        return {24'd0, n};
    endfunction

endpackage

// File: rtl/fir_coef_regfile.sv
// Coefficient register file: one synchronous write port and one combinational
// read port. The caller gates the write strobe.
module fir_coef_regfile
    import fir_pkg::*;
#(
    parameter  int COEF_W   = FIR_COEF_W,
    parameter  int MAX_TAPS = FIR_MAX_TAPS,
    localparam int TAP_W    = $clog2(MAX_TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [TAP_W-1:0]  waddr,
    input  logic [COEF_W-1:0] wdata,
    input  logic [TAP_W-1:0]  raddr,
    output logic [COEF_W-1:0] rdata
);

    logic [COEF_W-1:0] coef [MAX_TAPS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (we) begin
            coef[waddr] <= wdata;
        end
    end

    assign rdata = coef[raddr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Feeds (sample, coefficient) pairs from a circular delay line to the FIR MAC.
// Define FIR_SEQ_FLUSH_EN to add the synchronous history flush input.
//
// state      | meaning
// SEQ_IDLE   | waiting for a sample; coefficient writes allowed
// SEQ_STREAM | presenting pairs k = 0 .. N_eff-1; config frozen
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter  int DATA_W   = FIR_DATA_W,
    parameter  int COEF_W   = FIR_COEF_W,
    parameter  int MAX_TAPS = FIR_MAX_TAPS,
    localparam int TAP_W    = $clog2(MAX_TAPS)
) (
    input  logic              clk,
    input  logic              reset,
`ifdef FIR_SEQ_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [7:0]        n_taps,
    input  logic              cfg_we,
    input  logic [TAP_W-1:0]  cfg_addr,
    input  logic [COEF_W-1:0] cfg_coeff,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [COEF_W-1:0] m_coeff,
    output logic              m_first,
    output logic              m_last,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE   = SEQ_IDLE;
    localparam logic [0:0] ST_STREAM = SEQ_STREAM;

    logic [0:0]        state;
    logic [DATA_W-1:0] delay [MAX_TAPS];
    logic [TAP_W-1:0]  wr_ptr;
    logic [TAP_W-1:0]  k;
    logic [TAP_W-1:0]  k_nxt;
    logic [TAP_W-1:0]  rd_ptr;
    logic [TAP_W:0]    n_eff;
    logic [TAP_W:0]    n_acc;
    logic              flush_i;
    logic              accept;
    logic              advance;
    logic              last_nxt;
    logic              coef_we;
    logic [TAP_W-1:0]  coef_raddr;
    logic [COEF_W-1:0] coef_rd;
    logic [COEF_W-1:0] coef_k0;

`ifdef FIR_SEQ_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign s_ready  = (state == ST_IDLE) && !reset;
    assign accept   = s_valid && s_ready && !flush_i;
    assign advance  = (state == ST_STREAM) && m_valid && m_ready && !flush_i;
    assign k_nxt    = k + 1'b1;
    assign rd_ptr   = wr_ptr - k_nxt;
    assign last_nxt = ({1'b0, k_nxt} == (n_eff - 1'b1));
    assign n_acc    = (TAP_W+1)'(clamp_taps(n_taps, MAX_TAPS));

    assign coef_we    = cfg_we && (state == ST_IDLE);
    assign coef_raddr = (state == ST_IDLE) ? '0 : k_nxt;
    // A write to h[0] in the accept cycle must already appear on the first pair.
    assign coef_k0    = (coef_we && (cfg_addr == '0)) ? cfg_coeff : coef_rd;

    fir_coef_regfile #(
        .COEF_W   (COEF_W),
        .MAX_TAPS (MAX_TAPS)
    ) u_coef (
        .clk   (clk),
        .reset (reset),
        .we    (coef_we),
        .waddr (cfg_addr),
        .wdata (cfg_coeff),
        .raddr (coef_raddr),
        .rdata (coef_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_TAPS; i++) begin
                delay[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < MAX_TAPS; i++) begin
                delay[i] <= '0;
            end
        end else if (accept) begin
            delay[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            wr_ptr  <= '0;
            k       <= '0;
            n_eff   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_coeff <= '0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
        end else if (flush_i) begin
            state   <= ST_IDLE;
            wr_ptr  <= '0;
            k       <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_coeff <= '0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_STREAM;
                        n_eff   <= n_acc;
                        k       <= '0;
                        m_valid <= 1'b1;
                        busy    <= 1'b1;
                        m_data  <= s_data;
                        m_coeff <= coef_k0;
                        m_first <= 1'b1;
                        m_last  <= (n_acc == (TAP_W+1)'(1));
                    end
                end
                ST_STREAM: begin
                    if (advance) begin
                        if (m_last) begin
                            state   <= ST_IDLE;
                            wr_ptr  <= wr_ptr + 1'b1;
                            k       <= '0;
                            m_valid <= 1'b0;
                            busy    <= 1'b0;
                            m_first <= 1'b0;
                            m_last  <= 1'b0;
                        end else begin
                            k       <= k_nxt;
                            m_data  <= delay[rd_ptr];
                            m_coeff <= coef_rd;
                            m_first <= 1'b0;
                            m_last  <= last_nxt;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
